// File: rtl/multiport_register_file_if.sv
// rtl/multiport_register_file_if.sv - read, write and status signals of the multiport register file
interface multiport_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] adr1;
  logic [ADDR_W-1:0] adr2;
  logic [ADDR_W-1:0] adr3;
  logic [DATA_W-1:0] dout1;
  logic [DATA_W-1:0] dout2;
  logic [DATA_W-1:0] dout3;
  logic              wr_en_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] awr_a;
  logic [ADDR_W-1:0] awr_b;
  logic [DATA_W-1:0] din_a;
  logic [DATA_W-1:0] din_b;
  logic [BE_W-1:0]   be_a;
  logic [BE_W-1:0]   be_b;
  logic              busy;

  modport master (
    output adr1, adr2, adr3,
    output wr_en_a, wr_en_b, awr_a, awr_b, din_a, din_b, be_a, be_b,
    input  dout1, dout2, dout3, busy
  );

  modport slave (
    input  adr1, adr2, adr3,
    input  wr_en_a, wr_en_b, awr_a, awr_b, din_a, din_b, be_a, be_b,
    output dout1, dout2, dout3, busy
  );
endinterface

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - 3-read / 2-write register file with byte enables, bypass and clear engine
module multiport_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  multiport_register_file_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              clr_en;
  logic              wr_a;
  logic              wr_b;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] radr [3];
  logic [DATA_W-1:0] rdata [3];

  // A write takes effect only in IDLE, outside a reset edge, and never to a hardwired-zero entry 0
  assign wr_a = (state == IDLE) && !rst && bus.wr_en_a &&
                !((ZERO_REG != 0) && (bus.awr_a == '0));
  assign wr_b = (state == IDLE) && !rst && bus.wr_en_b &&
                !((ZERO_REG != 0) && (bus.awr_b == '0));

  // State and clear-pointer register; reset (re)starts the clear at entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear sequencing: one entry per edge, leave CLEAR after the last entry without wrapping cnt
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_en    = 1'b0;
    if (state == CLEAR) begin
      clr_en = 1'b1;
      if (cnt == ADDR_W'(DEPTH - 1)) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Storage update: clear slot, or byte-enabled writes where port B's later assignment wins on overlap
  always_ff @(posedge clk) begin
    if (clr_en && !rst) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_a && bus.be_a[i]) mem[bus.awr_a][8*i +: 8] <= bus.din_a[8*i +: 8];
        if (wr_b && bus.be_b[i]) mem[bus.awr_b][8*i +: 8] <= bus.din_b[8*i +: 8];
      end
    end
  end

  assign radr[0] = bus.adr1;
  assign radr[1] = bus.adr2;
  assign radr[2] = bus.adr3;

  // Read ports: stored word, optionally overlaid with this cycle's write bytes, then zero/busy masking
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rdata[k] = mem[radr[k]];
      if (BYPASS != 0) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wr_a && bus.be_a[i] && (bus.awr_a == radr[k])) rdata[k][8*i +: 8] = bus.din_a[8*i +: 8];
          if (wr_b && bus.be_b[i] && (bus.awr_b == radr[k])) rdata[k][8*i +: 8] = bus.din_b[8*i +: 8];
        end
      end
      if ((ZERO_REG != 0) && (radr[k] == '0)) rdata[k] = '0;
      if (state == CLEAR) rdata[k] = '0;
    end
  end

  assign bus.dout1 = rdata[0];
  assign bus.dout2 = rdata[1];
  assign bus.dout3 = rdata[2];
  assign bus.busy  = (state == CLEAR);
endmodule

// File: tb/tb_multiport_register_file.sv
// tb/tb_multiport_register_file.sv - directed table and sequence checks of multiport_register_file
module tb_multiport_register_file;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  multiport_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  multiport_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

  // main instance: zero register and bypass on
  multiport_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // reference-variant instance: zero register and bypass off, same stimulus
  multiport_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  assign bus0.adr1    = bus.adr1;
  assign bus0.adr2    = bus.adr2;
  assign bus0.adr3    = bus.adr3;
  assign bus0.wr_en_a = bus.wr_en_a;
  assign bus0.wr_en_b = bus.wr_en_b;
  assign bus0.awr_a   = bus.awr_a;
  assign bus0.awr_b   = bus.awr_b;
  assign bus0.din_a   = bus.din_a;
  assign bus0.din_b   = bus.din_b;
  assign bus0.be_a    = bus.be_a;
  assign bus0.be_b    = bus.be_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wa;
    logic [4:0]  aa;
    logic [31:0] da;
    logic [3:0]  ba;
    logic        wb;
    logic [4:0]  ab;
    logic [31:0] db;
    logic [3:0]  bb;
    logic [4:0]  r1, r2, r3;
    logic [31:0] e1, e2, e3;
    logic [31:0] z1, z2, z3;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    bus.awr_a = '0; bus.awr_b = '0;
    bus.din_a = '0; bus.din_b = '0;
    bus.be_a = '0; bus.be_b = '0;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    bus.adr1 = a1; bus.adr2 = a2; bus.adr3 = a3;
  endtask

  // counts edges until busy drops, sampling at the falling edge; limit exceeded is a failure
  task automatic wait_clear(output int n);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!bus.busy || n > 100) break;
    end
  endtask

  initial begin
    int n;
    compared   = 0;
    mismatched = 0;

    //             wa  aa  da            ba    wb  ab  db            bb    r1 r2  r3   e1            e2            e3            z1            z2            z3
    vecs[0] = '{1'b1, 1, 32'hF0F0F0F0, 4'hF, 1'b0, 0, 32'h0,        4'h0, 1, 2,  3,  32'hF0F0F0F0, 32'h0,        32'h0,        32'hF0F0F0F0, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 0, 32'h0,        4'h0, 1'b1, 2, 32'h0F0F0F0F, 4'hF, 1, 2,  3,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0};
    vecs[2] = '{1'b1, 0, 32'hFFFFFFFF, 4'hF, 1'b1, 0, 32'hFFFFFFFF, 4'hF, 0, 0,  1,  32'h0,        32'h0,        32'hF0F0F0F0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0};
    vecs[3] = '{1'b1, 5, 32'h11223344, 4'hF, 1'b0, 0, 32'h0,        4'h0, 5, 2,  1,  32'h11223344, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h11223344, 32'h0F0F0F0F, 32'hF0F0F0F0};
    vecs[4] = '{1'b1, 5, 32'hAAAAAAAA, 4'h3, 1'b1, 5, 32'hBBBBBBBB, 4'h6, 5, 5,  5,  32'h11BBBBAA, 32'h11BBBBAA, 32'h11BBBBAA, 32'h11BBBBAA, 32'h11BBBBAA, 32'h11BBBBAA};
    vecs[5] = '{1'b1, 6, 32'h55555555, 4'h0, 1'b1, 6, 32'h66666666, 4'h0, 6, 5,  2,  32'h0,        32'h11BBBBAA, 32'h0F0F0F0F, 32'h0,        32'h11BBBBAA, 32'h0F0F0F0F};
    vecs[6] = '{1'b1, 1, 32'h00770000, 4'h4, 1'b1, 31, 32'hCAFEBABE, 4'hF, 1, 31, 5, 32'hF077F0F0, 32'hCAFEBABE, 32'h11BBBBAA, 32'hF077F0F0, 32'hCAFEBABE, 32'h11BBBBAA};

    // reset for two edges, then clear
    rst = 1'b1;
    idle_inputs();
    set_reads(1, 2, 3);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_first_reset_edge", {31'h0, bus.busy}, 32'h1);
    check("dout1_during_reset", bus.dout1, 32'h0);
    check("dut0_busy_after_first_reset_edge", {31'h0, bus0.busy}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_second_reset_edge", {31'h0, bus.busy}, 32'h1);
    rst = 1'b0;
    wait_clear(n);
    check("clear_edge_count", n, 32);
    check("busy_after_clear", {31'h0, bus.busy}, 32'h0);
    check("dut0_busy_after_clear", {31'h0, bus0.busy}, 32'h0);

    // every entry reads zero on every port
    for (int a = 0; a < 32; a++) begin
      set_reads(a[4:0], a[4:0], a[4:0]);
      #1;
      check("sweep_dout1", bus.dout1, 32'h0);
      check("sweep_dout2", bus.dout2, 32'h0);
      check("sweep_dout3", bus.dout3, 32'h0);
      check("sweep_dut0_dout1", bus0.dout1, 32'h0);
      #1;
    end

    // table: write on one edge, read back with writes idle
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      bus.wr_en_a = vecs[v].wa; bus.awr_a = vecs[v].aa; bus.din_a = vecs[v].da; bus.be_a = vecs[v].ba;
      bus.wr_en_b = vecs[v].wb; bus.awr_b = vecs[v].ab; bus.din_b = vecs[v].db; bus.be_b = vecs[v].bb;
      set_reads(vecs[v].r1, vecs[v].r2, vecs[v].r3);
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      check($sformatf("vec%0d_dout1", v), bus.dout1, vecs[v].e1);
      check($sformatf("vec%0d_dout2", v), bus.dout2, vecs[v].e2);
      check($sformatf("vec%0d_dout3", v), bus.dout3, vecs[v].e3);
      check($sformatf("vec%0d_dut0_dout1", v), bus0.dout1, vecs[v].z1);
      check($sformatf("vec%0d_dut0_dout2", v), bus0.dout2, vecs[v].z2);
      check($sformatf("vec%0d_dut0_dout3", v), bus0.dout3, vecs[v].z3);
    end

    // bypass: same-cycle visibility with BYPASS=1, old value with BYPASS=0
    @(negedge clk);
    bus.wr_en_a = 1'b1; bus.awr_a = 7; bus.din_a = 32'hDEADBEEF; bus.be_a = 4'hF;
    bus.wr_en_b = 1'b1; bus.awr_b = 5; bus.din_b = 32'hCC000000; bus.be_b = 4'h8;
    set_reads(5, 0, 7);
    #1;
    check("bypass_dout3_pre_edge", bus.dout3, 32'hDEADBEEF);
    check("bypass_merge_dout1_pre_edge", bus.dout1, 32'hCCBBBBAA);
    check("nobypass_dout3_pre_edge", bus0.dout3, 32'h0);
    check("nobypass_dout1_pre_edge", bus0.dout1, 32'h11BBBBAA);
    check("nobypass_zero_reg_off_addr0", bus0.dout2, 32'hFFFFFFFF);
    check("zero_reg_on_addr0", bus.dout2, 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    check("bypass_dout3_post_edge", bus.dout3, 32'hDEADBEEF);
    check("nobypass_dout3_post_edge", bus0.dout3, 32'hDEADBEEF);
    check("nobypass_dout1_post_edge", bus0.dout1, 32'hCCBBBBAA);

    // reset 10 edges into a clear restarts the count; writes during busy are dropped
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("busy_mid_clear", {31'h0, bus.busy}, 32'h1);
    set_reads(4, 1, 7);
    #1;
    check("dout2_masked_mid_clear", bus.dout2, 32'h0);
    check("dout3_masked_mid_clear", bus.dout3, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.wr_en_a = 1'b1; bus.awr_a = 4; bus.din_a = 32'h12345678; bus.be_a = 4'hF;
    bus.wr_en_b = 1'b1; bus.awr_b = 9; bus.din_b = 32'h9ABCDEF0; bus.be_b = 4'hF;
    wait_clear(n);
    idle_inputs();
    check("restart_clear_edge_count", n, 32);
    set_reads(4, 1, 9);
    #1;
    check("blocked_write_addr4", bus.dout1, 32'h0);
    check("recleared_addr1", bus.dout2, 32'h0);
    check("blocked_write_addr9", bus.dout3, 32'h0);
    check("dut0_blocked_write_addr4", bus0.dout1, 32'h0);
    check("dut0_blocked_write_addr9", bus0.dout3, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
